// File: rtl/ccr_stack_if.sv
// ============================================================================
// Module      : ccr_stack_if
// Description : Bundle of the condition-code register's ALU-side flag write
//               port, the interrupt controller's push/pop strobes, and the
//               status outputs read by the branch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ccr_stack_if #(
    parameter int NFLAGS = 4,
    parameter int DEPTH  = 4,
    parameter int LW     = $clog2(DEPTH + 1)
);
    logic [NFLAGS-1:0] flags_in;
    logic [NFLAGS-1:0] flag_en;
    logic              push;
    logic              pop;
    logic              err_clr;
    logic [NFLAGS-1:0] flags_out;
    logic [LW-1:0]     level;
    logic              stack_full;
    logic              stack_empty;
    logic              ovf_err;
    logic              unf_err;

    // Driver side: ALU and interrupt controller
    modport master (
        output flags_in, flag_en, push, pop, err_clr,
        input  flags_out, level, stack_full, stack_empty, ovf_err, unf_err
    );

    // Register side: the condition-code stack itself
    modport slave (
        input  flags_in, flag_en, push, pop, err_clr,
        output flags_out, level, stack_full, stack_empty, ovf_err, unf_err
    );
endinterface

`default_nettype wire

// File: rtl/ccr_stack.sv
// ============================================================================
// Module      : ccr_stack
// Description : Condition-code register with a LIFO context stack for nested
//               interrupts. Push saves the active flag bank and hands the
//               handler a clean bank; pop restores the saved bank.
//               Build option CCR_FWD_EN: when defined, flags_out is the
//               combinational next value (same-cycle ALU writes forwarded);
//               otherwise flags_out is the registered active bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccr_stack #(
    parameter int NFLAGS = 4,
    parameter int DEPTH  = 4,
    parameter int LW     = $clog2(DEPTH + 1)
) (
    input  wire logic clk,
    input  wire logic rst,
    ccr_stack_if.slave bus
);

    logic [NFLAGS-1:0] act;
    logic [NFLAGS-1:0] act_nxt;
    logic [NFLAGS-1:0] merged;
    logic [NFLAGS-1:0] top;
    logic [NFLAGS-1:0] stack [DEPTH];
    logic [LW-1:0]     level;
    logic              full;
    logic              empty;
    logic              push_ok;
    logic              pop_ok;
    logic              ovf_evt;
    logic              unf_evt;
    logic              ovf_err;
    logic              unf_err;

    // Per-flag merge of ALU writes over the active bank, plus stack status
    always_comb begin
        merged  = (bus.flag_en & bus.flags_in) | (~bus.flag_en & act);
        full    = (level == LW'(DEPTH));
        empty   = (level == '0);
        // Simultaneous push and pop cancel into an ordinary cycle
        push_ok = bus.push & ~bus.pop & ~full;
        pop_ok  = bus.pop & ~bus.push & ~empty;
        ovf_evt = bus.push & ~bus.pop & full;
        unf_evt = bus.pop & ~bus.push & empty;
    end

    // Most recently saved context, i.e. the entry at level-1
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (level == LW'(i + 1)) begin
                top = stack[i];
            end
        end
    end

    // Next active bank: cleared on interrupt entry, restored on return,
    // otherwise the merged value (also on rejected push/pop)
    always_comb begin
        act_nxt = merged;
        if (push_ok) begin
            act_nxt = '0;
        end else if (pop_ok) begin
            act_nxt = top;
        end
    end

    // Active bank, depth counter and sticky error flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act     <= '0;
            level   <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            act <= act_nxt;
            if (push_ok) begin
                level <= level + LW'(1);
            end else if (pop_ok) begin
                level <= level - LW'(1);
            end
            // A new error in the same cycle as err_clr must survive
            if (ovf_evt) begin
                ovf_err <= 1'b1;
            end else if (bus.err_clr) begin
                ovf_err <= 1'b0;
            end
            if (unf_evt) begin
                unf_err <= 1'b1;
            end else if (bus.err_clr) begin
                unf_err <= 1'b0;
            end
        end
    end

    // Context storage: the merged value, including this cycle's writes,
    // belongs to the interrupted context and lands in slot [level]
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_ok && (level == LW'(i))) begin
                    stack[i] <= merged;
                end
            end
        end
    end

    // Output drive; forwarding build exposes the next value combinationally
    always_comb begin
`ifdef CCR_FWD_EN
        bus.flags_out = pop_ok ? top : merged;
`else
        bus.flags_out = act;
`endif
        bus.level       = level;
        bus.stack_full  = full;
        bus.stack_empty = empty;
        bus.ovf_err     = ovf_err;
        bus.unf_err     = unf_err;
    end

endmodule

`default_nettype wire

// File: tb/tb_ccr_stack.sv
// ============================================================================
// Module      : tb_ccr_stack
// Description : Directed self-checking bench for ccr_stack (NFLAGS=4,
//               DEPTH=4) with hand-computed expected values. Works in both
//               the CCR_FWD_EN and the default build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ccr_stack;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ccr_stack_if #(.NFLAGS(4), .DEPTH(4)) bus ();

    ccr_stack #(.NFLAGS(4), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.flags_in = 4'h0;
        bus.flag_en  = 4'h0;
        bus.push     = 1'b0;
        bus.pop      = 1'b0;
        bus.err_clr  = 1'b0;
    endtask

    // Apply one cycle of stimulus, then return to idle so the outputs show
    // the registered state in either build
    task automatic step(input logic [3:0] fi, input logic [3:0] fe,
                        input logic pu, input logic po, input logic ec);
        bus.flags_in = fi;
        bus.flag_en  = fe;
        bus.push     = pu;
        bus.pop      = po;
        bus.err_clr  = ec;
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        idle_inputs();

        // Reset state
        #12;
        check("rst_flags", bus.flags_out, 4'h0);
        check("rst_level", bus.level, 3'd0);
        check("rst_empty", bus.stack_empty, 1'b1);
        check("rst_full", bus.stack_full, 1'b0);
        check("rst_ovf", bus.ovf_err, 1'b0);
        check("rst_unf", bus.unf_err, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Per-flag write enables
        step(4'hF, 4'b0101, 1'b0, 1'b0, 1'b0);
        check("wr_mask1", bus.flags_out, 4'b0101);
        step(4'h0, 4'b1010, 1'b0, 1'b0, 1'b0);
        check("wr_mask2", bus.flags_out, 4'b0101);

        // Nest to full
        step(4'h9, 4'hF, 1'b0, 1'b0, 1'b0);
        check("act_9", bus.flags_out, 4'h9);
        step(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        check("push1_clean", bus.flags_out, 4'h0);
        check("push1_level", bus.level, 3'd1);
        step(4'h1, 4'hF, 1'b0, 1'b0, 1'b0);
        step(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        step(4'h2, 4'hF, 1'b0, 1'b0, 1'b0);
        step(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        step(4'h3, 4'hF, 1'b0, 1'b0, 1'b0);
        step(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        check("full_level", bus.level, 3'd4);
        check("full_flag", bus.stack_full, 1'b1);
        check("full_empty", bus.stack_empty, 1'b0);

        // Overflow: push while full keeps level, ACT takes M
        step(4'h7, 4'hF, 1'b1, 1'b0, 1'b0);
        check("ovf_err", bus.ovf_err, 1'b1);
        check("ovf_level", bus.level, 3'd4);
        check("ovf_act", bus.flags_out, 4'h7);

        // Unwind; the second pop carries a write that must be discarded
        step(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        check("pop1", bus.flags_out, 4'h3);
        check("pop1_level", bus.level, 3'd3);
        step(4'hE, 4'hF, 1'b0, 1'b1, 1'b0);
        check("pop2_wr_drop", bus.flags_out, 4'h2);
        step(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        check("pop3", bus.flags_out, 4'h1);
        step(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        check("pop4", bus.flags_out, 4'h9);
        check("pop4_empty", bus.stack_empty, 1'b1);

        // Underflow
        step(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        check("unf_err", bus.unf_err, 1'b1);
        check("unf_level", bus.level, 3'd0);
        check("unf_act", bus.flags_out, 4'h9);

        // Clear both sticky bits
        step(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        check("clr_ovf", bus.ovf_err, 1'b0);
        check("clr_unf", bus.unf_err, 1'b0);

        // Push with a full write: the write belongs to the saved context
        step(4'h6, 4'hF, 1'b1, 1'b0, 1'b0);
        check("pushwr_act", bus.flags_out, 4'h0);
        check("pushwr_level", bus.level, 3'd1);
        step(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        step(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        step(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        check("refill_full", bus.stack_full, 1'b1);

        // err_clr together with a new overflow: set wins
        step(4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
        check("clr_vs_ovf", bus.ovf_err, 1'b1);
        step(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        check("clr_ovf2", bus.ovf_err, 1'b0);

        // Push and pop together: normal cycle
        step(4'hC, 4'hF, 1'b1, 1'b1, 1'b0);
        check("pp_level", bus.level, 3'd4);
        check("pp_act", bus.flags_out, 4'hC);
        check("pp_ovf", bus.ovf_err, 1'b0);
        check("pp_unf", bus.unf_err, 1'b0);

        // Unwind down to the entry saved with the push-cycle write
        step(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        step(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        step(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        check("unw_level", bus.level, 3'd1);
        step(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        check("saved_6", bus.flags_out, 4'h6);

        // Asynchronous reset between edges at level 3
        step(4'h5, 4'hF, 1'b1, 1'b0, 1'b0);
        step(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        step(4'hA, 4'hF, 1'b1, 1'b0, 1'b0);
        step(4'hB, 4'hF, 1'b0, 1'b0, 1'b0);
        check("pre_arst_level", bus.level, 3'd3);
        check("pre_arst_flags", bus.flags_out, 4'hB);
        #1;
        rst = 1'b0;
        #1;
        check("arst_flags", bus.flags_out, 4'h0);
        check("arst_level", bus.level, 3'd0);
        check("arst_empty", bus.stack_empty, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        // Forwarding latency
        @(negedge clk);
        bus.flags_in = 4'h1;
        bus.flag_en  = 4'h1;
        #1;
`ifdef CCR_FWD_EN
        check("fwd_same", bus.flags_out[0], 1'b1);
`else
        check("fwd_same", bus.flags_out[0], 1'b0);
`endif
        @(posedge clk);
        #1;
        check("fwd_next", bus.flags_out[0], 1'b1);
        idle_inputs();
        #1;
        check("fwd_hold", bus.flags_out, 4'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ccr_stack.md
# ccr_stack

Parametrised condition-code register with a hardware context stack for nested interrupts. It holds one active bank of NFLAGS flags, with per-flag write enables. On interrupt entry it saves the active bank onto a DEPTH-entry LIFO; on return-from-interrupt it restores the bank. It sits beside the ALU in the execute stage, feeds the branch unit, and is driven by the interrupt controller's push/pop strobes.

## Interface
- NFLAGS, default 4: flag count. Bit order is {V, C, N, Z} for NFLAGS=4; extra flags go above V.
- DEPTH, default 4: number of saved contexts. Must be at least 1.
- LW, default $clog2(DEPTH+1): width of the `level` output (derived).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flags_in  in  NFLAGS  new flag values from the ALU.
- flag_en  in  NFLAGS  per-flag write enable.
- push  in  1  interrupt entry: save the context.
- pop  in  1  return from interrupt: restore the context.
- err_clr  in  1  clear the sticky error bits.
- flags_out  out  NFLAGS  current flags.
- level  out  LW  number of saved contexts, 0..DEPTH.
- stack_full  out  1  asserted when level == DEPTH.
- stack_empty  out  1  asserted when level == 0.
- ovf_err  out  1  sticky: a push was attempted while full.
- unf_err  out  1  sticky: a pop was attempted while empty.

## Operation
- Reset (rst=0, asynchronous): active bank = 0, all stack entries = 0, level = 0, ovf_err = 0, unf_err = 0. Consequently flags_out = 0, stack_empty = 1, stack_full = 0.
- Merged value: M[i] = flag_en[i] ? flags_in[i] : ACT[i].
- Normal cycle (no push, no pop): ACT <= M.
- Push, not full:
  - stack[level] <= M, so writes in the push cycle belong to the interrupted context.
  - ACT <= 0, giving a clean handler context.
  - level <= level+1.
- Push while full:
  - Stack and level are unchanged.
  - ACT <= M.
  - ovf_err <= 1.
- Pop, not empty:
  - ACT <= stack[level-1]; any flag writes in the same cycle are discarded.
  - level <= level-1.
- Pop while empty:
  - Stack and level are unchanged.
  - ACT <= M.
  - unf_err <= 1.
- Push and pop in the same cycle: treated as a normal cycle. ACT <= M, level is unchanged, and no error is raised.
- err_clr clears both sticky bits. If a new error occurs in the same cycle, the set wins.
- Stack entries above level keep stale data. They are never visible at flags_out.
- level is a plain up/down counter with no wrap-around. It saturates at DEPTH and at 0 via the error paths above.

## Timing
- All state is registered. level, stack_full, stack_empty and the error bits update on the same edge that accepts push/pop, and are visible in the next cycle.
- flags_out latency: see Configuration. Without forwarding it is 1 cycle from a flag_en write, push or pop.
- Back-to-back push/pop is allowed every cycle. Example: push then pop on consecutive cycles returns the pre-push M by the second cycle after the push.
- Reset asserted mid-operation discards all contexts immediately, without waiting for a clock edge.

## Configuration
- Macro: CCR_FWD_EN.
- Defined: flags_out is combinational.
  - When pop=0 or the stack is empty: flags_out = M, so same-cycle ALU writes are forwarded to the branch unit.
  - Pop accepted: flags_out = stack[level-1].
  - Push accepted: flags_out = M, which is the interrupted context's value this cycle.
- Not defined: flags_out = ACT, a pure register output with 1-cycle latency.
- State, level and errors are identical in both builds.

## Test plan
- Reset/write: release rst, flag_en=4'b0101, flags_in=4'b1111 → next cycle flags_out=4'b0101. Then flag_en=4'b1010, flags_in=4'b0000 → flags_out stays 4'b0101.
- Nest to full (DEPTH=4): set ACT=4'b1001, then push 4 times, writing 4'h1/4'h2/4'h3 between pushes → level=4 and stack_full=1. Pop 4 times → flags_out reads 4'h3, 4'h2, 4'h1, 4'b1001, and stack_empty=1.
- Overflow/underflow:
  - Fifth push while full → ovf_err=1, level stays at 4.
  - Pop at level 0 → unf_err=1.
  - err_clr → both errors clear next cycle.
  - err_clr together with a new overflow → ovf_err stays 1.
- Same-cycle events:
  - push with flag_en=4'hF, flags_in=4'h6 → saved entry=4'h6 and ACT=0.
  - pop with a write → the write is discarded.
  - push+pop together → level unchanged and ACT=M.
- Async reset: assert rst between clock edges at level=3 → flags_out=0, level=0 and stack_empty=1 before the next edge.
- Forwarding, run in both builds: flag_en=4'h1, flags_in=4'h1 → flags_out[0]=1 in the same cycle with CCR_FWD_EN, one cycle later without it.
